// File: rtl/load_store_unit.sv
// load_store_unit: rv32i memory stage; one req/ack data-bus transaction per
// accepted request, with misaligned/illegal detection and load extension.
// Ports: clk, rst_n (async, active low); req_valid/req_ready, is_store,
//   funct3, addr, wdata (request); mem_req/we/addr/be/wdata, mem_ack,
//   mem_rdata (data bus); resp_valid, resp_data, resp_err (write-back).
// Optional: define LSU_TIMEOUT_EN to abort a BUS phase after TIMEOUT_CYCLES
//   cycles without mem_ack (reported as an error response).
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TW             = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP,
        S_ERR
    } state_t;

    if (2 ** TW <= TIMEOUT_CYCLES) begin : g_cfg_chk
        $error("TW too narrow for TIMEOUT_CYCLES");
    end

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic        r_is_store;
    logic [31:0] r_rdata_ext;

    logic        w_accept;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_is_word;
    logic        w_legal;
    logic        w_misal;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wd;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic        w_bus_ack;
    logic        w_timeout;

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_bus_ack = mem_ack && (r_state == S_BUS);

    // funct3[1:0] carries the access size for both loads and stores.
    assign w_is_byte = (funct3[1:0] == 2'b00);
    assign w_is_half = (funct3[1:0] == 2'b01);
    assign w_is_word = (funct3[1:0] == 2'b10);

    // Stores have no unsigned forms; loads allow 100/101 but not 110.
    assign w_legal = is_store ? (funct3[2] == 1'b0 && !funct3[1:0] == 2'b11 ? 1'b1 : (funct3[2] == 1'b0 && funct3[1:0] != 2'b11))
                              : (funct3[1:0] != 2'b11 && !(funct3[2] && w_is_word));
    assign w_misal = (w_is_half && addr[0]) || (w_is_word && (addr[1:0] != 2'b00));
    assign w_bad   = !w_legal || w_misal;

    always_comb begin
        w_be = 4'b1111;
        w_wd = wdata;
        unique case (1'b1)
            w_is_byte: begin
                w_be = 4'b0001 << addr[1:0];
                w_wd = {4{wdata[7:0]}};
            end
            w_is_half: begin
                w_be = 4'b0011 << addr[1:0];
                w_wd = {2{wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        unique case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'd0, w_byte};
            3'b101:  w_load_ext = {16'd0, w_half};
            default: w_load_ext = mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [TW-1:0] r_tcnt;

    // Counts completed BUS cycles without ack; the limit is hit in the
    // TIMEOUT_CYCLES-th such cycle.
    assign w_timeout = (r_state == S_BUS) && !mem_ack
                       && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (w_accept) begin
            r_tcnt <= '0;
        end else if (r_state == S_BUS && !mem_ack) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_bad ? S_ERR : S_BUS;
                end
            end
            S_BUS: begin
                // An ack in the limit cycle still completes normally.
                if (mem_ack) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_is_store  <= 1'b0;
            r_rdata_ext <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mem_we    <= is_store;
                r_mem_addr  <= {addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wd;
                r_funct3    <= funct3;
                r_lane      <= addr[1:0];
                r_is_store  <= is_store;
            end
            if (w_bus_ack) begin
                r_rdata_ext <= r_is_store ? 32'd0 : w_load_ext;
            end
        end
    end

    // Bus fields read as zero outside BUS so nothing stale leaks out.
    assign req_ready  = (r_state == S_IDLE);
    assign mem_req    = (r_state == S_BUS);
    assign mem_we     = mem_req && r_mem_we;
    assign mem_addr   = mem_req ? r_mem_addr : 32'd0;
    assign mem_be     = mem_req ? r_mem_be : 4'd0;
    assign mem_wdata  = mem_req ? r_mem_wdata : 32'd0;
    assign resp_valid = (r_state == S_RESP) || (r_state == S_ERR);
    assign resp_err   = (r_state == S_ERR);
    assign resp_data  = (r_state == S_RESP) ? r_rdata_ext : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions with a per-cycle expectation
// model derived from the access rules, plus literal checks on key vectors.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    load_store_unit #(.TIMEOUT_CYCLES(16), .TW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          chk_en = 1'b0;
    logic        exp_ready, exp_mreq, exp_we, exp_rv, exp_err;
    logic [31:0] exp_addr, exp_wd, exp_data;
    logic [3:0]  exp_be;
    bit          exp_chk_wd;

    logic [31:0] last_data, last_addr, last_wd;
    logic [3:0]  last_be;
    logic        last_err;
    int          rv_count = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("mem_req", 32'(mem_req), 32'(exp_mreq));
            if (exp_mreq) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", mem_addr, exp_addr);
                check("mem_be", 32'(mem_be), 32'(exp_be));
                if (exp_chk_wd) check("mem_wdata", mem_wdata, exp_wd);
            end
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("resp_err", 32'(resp_err), 32'(exp_err));
                check("resp_data", resp_data, exp_data);
            end
        end
        if (mem_req) begin
            last_addr = mem_addr;
            last_be   = mem_be;
            last_wd   = mem_wdata;
        end
        if (resp_valid) begin
            last_data = resp_data;
            last_err  = resp_err;
            rv_count++;
        end
    end

    // ---- reference rules ----
    function automatic int f_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit f_bad(input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
        bit legal;
        if (st) legal = (f3 == 0 || f3 == 1 || f3 == 2);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (!legal) return 1'b1;
        return (a % f_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3,
                                        input logic [31:0] a);
        int m;
        m = ((1 << f_size(f3)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] f3,
                                         input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = f_size(f3);
        r = 0;
        for (int i = 0; i < 4; i++)
            r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] f_ld(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
        logic [31:0] mask, v;
        int sz;
        sz = f_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        v = (rd >> (8 * (a % 4))) & mask;
        if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle_exp();
        exp_ready = 1; exp_mreq = 0; exp_rv = 0; exp_err = 0;
        exp_we = 0; exp_addr = 0; exp_be = 0; exp_wd = 0; exp_data = 0;
        exp_chk_wd = 0;
    endtask

    task automatic idle_inputs();
        req_valid = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_ack = 0; mem_rdata = 32'hBAD0_BAD0;
    endtask

    // One transaction starting in the current (idle) cycle. Ack arrives in
    // BUS cycle k. req_valid is held (with junk) while busy to prove it is
    // ignored; stray_ack pulses mem_ack outside BUS.
    task automatic run_txn(input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int k, input logic [31:0] rd,
                           input bit stray_ack);
        bit bad;
        bad = f_bad(st, f3, a);
        req_valid = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_ack = stray_ack; mem_rdata = 32'hBAD0_BAD0;
        set_idle_exp();
        @(posedge clk); #1;
        mem_ack = 0;
        exp_ready = 0;
        if (bad) begin
            req_valid = 0;
            exp_rv = 1; exp_err = 1; exp_data = 0;
        end else begin
            addr = ~a; wdata = ~wd; funct3 = 3'b111; is_store = ~st;
            for (int c = 1; c <= k; c++) begin
                exp_mreq = 1; exp_we = st;
                exp_addr = {a[31:2], 2'b00};
                exp_be = f_be(f3, a); exp_wd = f_wd(f3, wd); exp_chk_wd = st;
                mem_ack = (c == k);
                mem_rdata = (c == k) ? rd : 32'hBAD0_BAD0;
                @(posedge clk); #1;
            end
            req_valid = 0; mem_ack = stray_ack; mem_rdata = 32'hBAD0_BAD0;
            exp_mreq = 0; exp_chk_wd = 0;
            exp_rv = 1; exp_err = 0; exp_data = st ? 32'd0 : f_ld(f3, a, rd);
        end
        @(posedge clk); #1;
        idle_inputs();
        set_idle_exp();
    endtask

    initial begin
        int rv_before;
        idle_inputs();
        set_idle_exp();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst outputs", mem_addr | mem_wdata | resp_data
              | 32'(mem_be) | 32'(mem_we) | 32'(resp_err), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        chk_en = 1;

        run_txn(0, 3'b000, 32'h0000_1003, 0, 2, 32'h80FF_0000, 0);
        check("LB data", last_data, 32'hFFFF_FF80);
        check("LB be", 32'(last_be), 32'h8);
        check("LB addr", last_addr, 32'h0000_1000);
        check("LB err", 32'(last_err), 32'd0);

        run_txn(0, 3'b101, 32'h0000_2002, 0, 1, 32'h8001_1234, 1);
        check("LHU data", last_data, 32'h0000_8001);
        check("LHU be", 32'(last_be), 32'hC);

        run_txn(1, 3'b000, 32'h0000_0005, 32'hDEAD_BEA5, 3, 0, 0);
        check("SB be", 32'(last_be), 32'h2);
        check("SB wdata", last_wd, 32'hA5A5_A5A5);
        check("SB data", last_data, 32'd0);

        run_txn(0, 3'b010, 32'h0000_0006, 0, 1, 0, 0);
        check("LW misal err", 32'(last_err), 32'd1);
        run_txn(0, 3'b011, 32'h0000_0000, 0, 1, 0, 0);
        check("f3 011 err", 32'(last_err), 32'd1);
        run_txn(1, 3'b100, 32'h0000_0010, 1, 1, 0, 0);
        run_txn(0, 3'b001, 32'h0000_0003, 0, 1, 0, 0);
        run_txn(0, 3'b001, 32'h0000_0402, 0, 2, 32'h8001_7FFF, 0);
        check("LH data", last_data, 32'hFFFF_8001);
        run_txn(0, 3'b100, 32'h0000_0401, 0, 1, 32'h1122_C344, 1);
        run_txn(0, 3'b010, 32'h0000_0800, 0, 4, 32'hCAFE_F00D, 0);
        check("LW data", last_data, 32'hCAFE_F00D);
        run_txn(1, 3'b001, 32'h0000_0C02, 32'h1234_ABCD, 1, 0, 0);
        check("SH wdata", last_wd, 32'hABCD_ABCD);
        run_txn(1, 3'b010, 32'h0000_0C04, 32'h0BAD_F00D, 2, 0, 0);
        run_txn(0, 3'b000, 32'h0000_0C00, 0, 16, 32'h0000_007F, 0);

`ifdef LSU_TIMEOUT_EN
        req_valid = 1; funct3 = 3'b010; addr = 32'h0000_0100;
        @(posedge clk); #1;
        req_valid = 0;
        exp_ready = 0;
        for (int c = 1; c <= 16; c++) begin
            exp_mreq = 1; exp_we = 0; exp_addr = 32'h100; exp_be = 4'hF;
            @(posedge clk); #1;
        end
        exp_mreq = 0; exp_rv = 1; exp_err = 1; exp_data = 0;
        @(posedge clk); #1;
        set_idle_exp();
        check("timeout err", 32'(last_err), 32'd1);
`else
        run_txn(0, 3'b010, 32'h0000_0100, 0, 40, 32'h5555_AAAA, 0);
        check("long wait data", last_data, 32'h5555_AAAA);
`endif

        // Asynchronous reset while a bus request is outstanding.
        req_valid = 1; funct3 = 3'b010; addr = 32'h0000_0200;
        @(posedge clk); #1;
        req_valid = 0;
        exp_ready = 0; exp_mreq = 1; exp_we = 0;
        exp_addr = 32'h200; exp_be = 4'hF;
        @(negedge clk); #2;
        chk_en = 0;
        rv_before = rv_count;
        check("pre-rst mem_req", 32'(mem_req), 32'd1);
        rst_n = 0;
        #1;
        check("async rst mem_req", 32'(mem_req), 32'd0);
        check("async rst req_ready", 32'(req_ready), 32'd1);
        mem_ack = 1;
        @(posedge clk); #1;
        mem_ack = 0;
        rst_n = 1;
        set_idle_exp();
        chk_en = 1;
        repeat (4) @(posedge clk);
        #1;
        check("no resp after rst", 32'(rv_count - rv_before), 32'd0);

        run_txn(0, 3'b000, 32'h0000_0302, 0, 1, 32'h00AB_0000, 0);
        check("post-rst LB", last_data, 32'hFFFF_FFAB);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
